// File: rtl/softmax_pkg.sv
// Shared definitions for the pseudo-softmax datapath: field widths,
// serializer state encoding and the mantissa/exponent decode helper.
package softmax_pkg;

  localparam int MANT_W = 3;
  localparam int EXP_W  = 3;
  localparam int FIX_W  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } ser_state_t;

  // Expand a mantissa/exponent pair to its fixed-point value.
  // mant=0, exp=0 is reserved to mean an exact zero.
  function automatic logic [FIX_W-1:0] decode_fix(
    input logic [MANT_W-1:0] mant,
    input logic [EXP_W-1:0]  ex
  );
    logic [FIX_W-1:0] base;
    base = FIX_W'({1'b1, mant});
    if (mant == '0 && ex == '0) begin
      return '0;
    end
    return base << ex;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes into a full FIFO and
// pops from an empty one are ignored. Head data is visible combinationally.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/softmax_result_decoder.sv
// Decodes mantissa/exponent results to 11-bit fixed point, buffers them,
// and serializes each as a high byte followed by a low byte.
module softmax_result_decoder
  import softmax_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [FIX_W-1:0] dec_val;
  logic [FIX_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             push;
  logic             pop;

  ser_state_t       state_reg;
  logic [FIX_W-1:0] hold_reg;
  logic             out_valid_reg;
  logic [7:0]       out_data_reg;
  logic             out_last_reg;

  assign dec_val   = decode_fix(mant_in, exp_in);
  assign in_ready  = (fifo_count < CW'(DEPTH)) && !fifo_full;
  assign push      = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

  sync_fifo #(
    .WIDTH (FIX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (dec_val),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Pop the head whenever the serializer is ready to start a new result.
  always_comb begin
    pop = 1'b0;
    case (state_reg)
      IDLE:    pop = !fifo_empty;
      LO:      pop = out_ready && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // Serializer FSM with registered byte outputs; holds them while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            state_reg     <= HI;
            hold_reg      <= head;
            out_valid_reg <= 1'b1;
            out_data_reg  <= {5'b0, head[10:8]};
            out_last_reg  <= 1'b0;
          end
        end
        HI: begin
          if (out_ready) begin
            state_reg    <= LO;
            out_data_reg <= hold_reg[7:0];
            out_last_reg <= 1'b1;
          end
        end
        LO: begin
          if (out_ready) begin
            if (!fifo_empty) begin
              state_reg     <= HI;
              hold_reg      <= head;
              out_valid_reg <= 1'b1;
              out_data_reg  <= {5'b0, head[10:8]};
              out_last_reg  <= 1'b0;
            end else begin
              state_reg     <= IDLE;
              out_valid_reg <= 1'b0;
              out_data_reg  <= '0;
              out_last_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          out_data_reg  <= '0;
          out_last_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_result_decoder.sv
// Directed bench for softmax_result_decoder: latency, decode values,
// back-pressure, stall stability and mid-transfer reset.
module tb_softmax_result_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] mant_in;
  logic [2:0] exp_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  softmax_result_decoder #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present one pair at the current falling edge and hold it across one rising edge.
  task automatic push_pair(input logic [2:0] m, input logic [2:0] e);
    in_valid = 1'b1;
    mant_in  = m;
    exp_in   = e;
    chk("push_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    $display("push mant=%0d exp=%0d", m, e);
  endtask

  // One result through an idle decoder with out_ready held high.
  task automatic run_single(input logic [2:0] m, input logic [2:0] e,
                            input logic [7:0] hi, input logic [7:0] lo);
    push_pair(m, e);
    chk("lat_not_yet", out_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("hi_valid", out_valid, 1);
    chk("hi_data", out_data, hi);
    chk("hi_last", out_last, 0);
    @(posedge clk); @(negedge clk);
    chk("lo_valid", out_valid, 1);
    chk("lo_data", out_data, lo);
    chk("lo_last", out_last, 1);
    @(posedge clk); @(negedge clk);
    chk("idle_after", out_valid, 0);
    $display("single mant=%0d exp=%0d -> %02h %02h", m, e, hi, lo);
  endtask

  logic [8:0] drain_exp [9];
  logic [8:0] stall_exp [6];

  initial begin
    int idx;
    logic r;

    rst_n = 1'b0; in_valid = 1'b0; mant_in = '0; exp_in = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    // Basic decode values, including the zero code and non-zero neighbours.
    out_ready = 1'b1;
    run_single(3'd5, 3'd3, 8'h00, 8'h68);
    run_single(3'd7, 3'd7, 8'h07, 8'h80);
    run_single(3'd0, 3'd0, 8'h00, 8'h00);
    run_single(3'd0, 3'd5, 8'h01, 8'h00);
    run_single(3'd3, 3'd0, 8'h00, 8'h0B);

    // Back-pressure: the holding register takes the first result, four fill the FIFO.
    out_ready = 1'b0;
    push_pair(3'd1, 3'd0);
    push_pair(3'd2, 3'd1);
    push_pair(3'd3, 3'd2);
    push_pair(3'd4, 3'd4);
    push_pair(3'd6, 3'd5);
    chk("full_in_ready", in_ready, 0);
    chk("full_hi_valid", out_valid, 1);
    chk("full_hi_data", out_data, 8'h00);
    in_valid = 1'b1; mant_in = 3'd7; exp_in = 3'd1;
    @(posedge clk); @(negedge clk);
    chk("blocked_in_ready", in_ready, 0);
    chk("stalled_hi_data", out_data, 8'h00);
    chk("stalled_hi_last", out_last, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain_exp[0] = 9'h109; drain_exp[1] = 9'h000; drain_exp[2] = 9'h114;
    drain_exp[3] = 9'h000; drain_exp[4] = 9'h12C; drain_exp[5] = 9'h000;
    drain_exp[6] = 9'h1C0; drain_exp[7] = 9'h001; drain_exp[8] = 9'h1C0;
    @(posedge clk); @(negedge clk);
    chk("lo_full_in_ready", in_ready, 0);
    for (int i = 0; i < 9; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_byte", {out_last, out_data}, drain_exp[i]);
      $display("drain byte %0d last=%0b data=%02h", i, out_last, out_data);
      @(posedge clk); @(negedge clk);
    end
    chk("drain_idle", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);

    // Random stalls on a three-result stream: each byte must hold until taken.
    out_ready = 1'b0;
    push_pair(3'd5, 3'd3);
    push_pair(3'd7, 3'd7);
    push_pair(3'd1, 3'd6);
    stall_exp[0] = 9'h000; stall_exp[1] = 9'h168; stall_exp[2] = 9'h007;
    stall_exp[3] = 9'h180; stall_exp[4] = 9'h002; stall_exp[5] = 9'h140;
    idx = 0;
    for (int c = 0; c < 80 && idx < 6; c++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_byte", {out_last, out_data}, stall_exp[idx]);
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      $display("stall cycle %0d ready=%0b last=%0b data=%02h", c, r, out_last, out_data);
      @(posedge clk);
      if (r) idx++;
      @(negedge clk);
    end
    chk("stall_all_bytes", idx, 6);
    chk("stall_idle", out_valid, 0);

    // Reset while in LO with two results queued.
    out_ready = 1'b0;
    push_pair(3'd2, 3'd2);
    push_pair(3'd4, 3'd3);
    push_pair(3'd6, 3'd4);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_in_lo", out_last, 1);
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    run_single(3'd3, 3'd0, 8'h00, 8'h0B);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("post_rst_quiet", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
